// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register-file scoreboard.
// Holds the register index width, the hard-wired zero register index and
// the width and maximum value of each pending-write counter.
package cpu_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  localparam int SB_CNT_W = 2;
  localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;

endpackage

// File: rtl/grf_sb_cell.sv
// One pending-write counter of the scoreboard, covering a single
// architectural register.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   inc_i       an accepted issue targets this register
//   dec_i       a writeback retires to this register
//   clr_i       synchronous clear, overrides inc/dec
//   cnt_o       current number of in-flight writes
//   busy_o      counter is non-zero
//   underflow_o writeback arrived while the counter was already zero
module grf_sb_cell
  import cpu_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             incOk, decOk;

  // Guards keep the counter inside its range even if the issue gating upstream
  // were ever bypassed; a dec at zero is reported instead of wrapping.
  always_comb begin
    incOk = inc_i & (cnt_q != CntMax);
    decOk = dec_i & (cnt_q != '0);
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (incOk && !decOk) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (decOk && !incOk) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign busy_o      = (cnt_q != '0);
  assign underflow_o = dec_i & (cnt_q == '0);

endmodule

// File: rtl/grf_scoreboard.sv
// Hazard scoreboard for the 32x32 general register file. Counts in-flight
// writes per register and holds decode issue until every read source has
// no outstanding write and the destination counter has room.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   issue_*             decode issue handshake and operand fields
//   wb_valid, wb_rd     writeback retirement from the W stage
//   flush               synchronous clear of all pending writes
//   busy_mask           per-register busy flags (bit 0 always 0)
//   stall_cycles        saturating count of stalled issue cycles
//   err_underflow       sticky flag: writeback with nothing pending
module grf_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int CNT_W  = SB_CNT_W,
  parameter int PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [REG_IDX_W-1:0] issue_rs,
  input  logic                 issue_rs_used,
  input  logic [REG_IDX_W-1:0] issue_rt,
  input  logic                 issue_rt_used,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_we,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_mask,
  output logic [PERF_W-1:0]    stall_cycles,
  output logic                 err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  cntVec [NREG];
  logic [NREG-1:0]   ufVec;
  logic              hazardRs, hazardRt, sat, accept;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic              err_q, err_d;

  // Register 0 has no counter: it reads as idle and can never underflow.
  assign cntVec[0]    = '0;
  assign busy_mask[0] = 1'b0;
  assign ufVec[0]     = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gCell
    grf_sb_cell #(.CNT_W(CNT_W)) uCell (
      .clk         (clk),
      .reset       (reset),
      .inc_i       (accept & issue_we & (issue_rd == REG_IDX_W'(r))),
      .dec_i       (wb_valid & (wb_rd == REG_IDX_W'(r))),
      .clr_i       (flush),
      .cnt_o       (cntVec[r]),
      .busy_o      (busy_mask[r]),
      .underflow_o (ufVec[r])
    );
  end

  // Ready looks only at registered counts, so a same-cycle writeback does not
  // release a stall until the following cycle.
  always_comb begin
    hazardRs    = issue_rs_used & (issue_rs != REG_ZERO) & (cntVec[issue_rs] != '0);
    hazardRt    = issue_rt_used & (issue_rt != REG_ZERO) & (cntVec[issue_rt] != '0);
    sat         = issue_we & (issue_rd != REG_ZERO) & (cntVec[issue_rd] == CntMax);
    issue_ready = !(hazardRs | hazardRt | sat);
    accept      = issue_valid & issue_ready;
  end

  // Stall counter saturates at all-ones; the error flag only clears on reset.
  always_comb begin
    stall_d = stall_q;
    if (issue_valid && !issue_ready && (stall_q != '1)) begin
      stall_d = stall_q + PERF_W'(1);
    end
    err_d = err_q | (|ufVec);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Hazard controller for the 32x32 general register file in the pipelined CPU.
- Tracks outstanding writes per architectural register and gates instruction issue in decode until source operands are stable.
- Issue handshake sits between decode and execute; writeback completions arrive from the W stage.
- Register 0 is never tracked, matching the file's hard-wired zero.

Parameters:
- NREG, 32, number of architectural registers; index width is 5.
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2^CNT_W-1 = 3.
- PERF_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- issue_valid  in  1  decode presents an instruction
- issue_ready  out  1  scoreboard accepts it this cycle
- issue_rs  in  5  source A register index
- issue_rs_used  in  1  source A is read
- issue_rt  in  5  source B register index
- issue_rt_used  in  1  source B is read
- issue_rd  in  5  destination register index
- issue_we  in  1  instruction writes issue_rd
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  5  index of the retiring write
- flush  in  1  synchronous clear of all pending state
- busy_mask  out  32  bit r = 1 when cnt[r] != 0; bit 0 always 0
- stall_cycles  out  PERF_W  cycles with issue_valid=1 and issue_ready=0, saturating
- err_underflow  out  1  sticky; wb_valid arrived for a register with cnt=0

Behaviour:
- State: cnt[1..31] (CNT_W bits each), stall_cycles, err_underflow. cnt[0] does not exist and always reads as 0.
- Reset (reset=0, async): all cnt=0, stall_cycles=0, err_underflow=0. Outputs: busy_mask=0; issue_ready=1 whenever no hazard applies.
- hazard_rs = issue_rs_used & (issue_rs!=0) & (cnt[issue_rs]!=0). hazard_rt is the same with issue_rt.
- sat = issue_we & (issue_rd!=0) & (cnt[issue_rd]==CNT_MAX).
- issue_ready = !(hazard_rs | hazard_rt | sat). It is combinational from registered cnt only.
- No same-cycle bypass: a wb_valid clearing a register does not raise issue_ready in that cycle. Ready rises the cycle after the clear.
- issue_ready does not depend on issue_valid.
- accept = issue_valid & issue_ready. inc[r] = accept & issue_we & (issue_rd==r) & (r!=0). dec[r] = wb_valid & (wb_rd==r) & (r!=0) & (cnt[r]!=0).
- Next cnt[r] = cnt[r] + inc[r] - dec[r].
  - inc and dec on the same r in the same cycle leave the count unchanged.
  - Underflow and overflow are impossible by construction.
- wb_valid with wb_rd=0: ignored, no error.
- wb_valid with wb_rd!=0 and cnt[wb_rd]=0: counter held at 0, err_underflow set to 1. It stays 1 until reset; flush does not clear it.
- flush=1: at the next edge all cnt=0, overriding any inc/dec in that cycle. issue_ready is still computed from the pre-flush state during the flush cycle. stall_cycles and err_underflow are unaffected.
- stall_cycles increments by 1 on each edge where issue_valid=1 and issue_ready=0. It holds at all-ones once reached; there is no wrap.
- busy_mask is registered-state derived, with no combinational path from inputs.
- Issue-to-busy latency: 1 cycle. Writeback-to-clear latency: 1 cycle.
- WAW is allowed: multiple in-flight writes to the same rd are counted. The register is busy until every write has retired.

Decomposition:
- Shared package (cpu_pkg): REG_IDX_W=5, REG_ZERO=5'd0, SB_CNT_W, SB_CNT_MAX.
- One sub-module, grf_sb_cell: a single up/down saturating-guarded counter with inc, dec, clr, busy and underflow outputs, instantiated 31 times via generate.
- The top level holds decode compare, ready logic, the perf counter and the sticky error.

Test Plan:
- Reset release → busy_mask=0, stall_cycles=0, err_underflow=0; issue rs=3,rt=4 used → issue_ready=1.
- Issue rd=5, we=1, accept → next cycle busy_mask=0x20. Issue rs=5 used → issue_ready=0, stall_cycles counts 1,2,…. wb_rd=5 → ready=1 one cycle later.
- Three accepted writes to rd=7 → cnt=3. Fourth write to rd=7 → ready=0 (sat). One wb_rd=7 → ready=1 next cycle. Same-cycle issue rd=7 plus wb rd=7 → cnt unchanged.
- Issue rd=0 we=1 → busy_mask stays 0. wb_rd=0 → err_underflow stays 0. Source rs=0 used → never stalls.
- wb_rd=9 with cnt[9]=0 → err_underflow=1, cnt[9]=0. Subsequent flush → err_underflow still 1.
- Pending rd=2,6. Assert flush with a simultaneous accepted issue rd=8 → next cycle busy_mask=0. Drive reset=0 mid-stall → all outputs cleared immediately, without waiting for clk.
